// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state, port-ID and access-size encodings for the memory port arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} arb_state_t;
  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_DATA = 1'b1;
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
endpackage

// File: rtl/mux2.sv
// mux2: generic 2-to-1 mux, b_i selected when sel_i is high
module mux2 #(
  parameter int W = 1
) (
  input  logic         sel_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] y_o
);
  assign y_o = sel_i ? b_i : a_i;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one 1-cycle-latency memory port between fetch (port 0) and load/store (port 1)
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter bit FAIR = 1'b1
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        REQ0_VALID,
  input  logic [31:0] REQ0_ADDR,
  input  logic        REQ0_WE,
  input  logic [31:0] REQ0_WDATA,
  input  logic [1:0]  REQ0_SIZE,
  output logic        REQ0_READY,
  input  logic        REQ1_VALID,
  input  logic [31:0] REQ1_ADDR,
  input  logic        REQ1_WE,
  input  logic [31:0] REQ1_WDATA,
  input  logic [1:0]  REQ1_SIZE,
  output logic        REQ1_READY,
  output logic        RSP0_VALID,
  output logic [31:0] RSP0_RDATA,
  output logic        RSP1_VALID,
  output logic [31:0] RSP1_RDATA,
  output logic        MEM_VALID,
  input  logic        MEM_READY,
  output logic [31:0] MEM_ADDR,
  output logic        MEM_WE,
  output logic [31:0] MEM_WDATA,
  output logic [1:0]  MEM_SIZE,
  input  logic [31:0] MEM_RDATA,
  output logic        SEL
);
  arb_state_t state_q, state_d;
  logic last_q, pend_v_q, pend_id_q;
  logic owner, mem_v, acc;
  logic [31:0] addr_m, wdata_m;
  logic we_m;
  logic [1:0] size_m;
  // a locked owner overrides arbitration; with no requester, SEL parks on last_gnt
  always_comb begin
    owner = state_q == LOCK0 ? PORT_IF :
            state_q == LOCK1 ? PORT_DATA :
            (REQ0_VALID & REQ1_VALID) ? (FAIR ? ~last_q : PORT_DATA) :
            REQ1_VALID ? PORT_DATA :
            REQ0_VALID ? PORT_IF : last_q;
    mem_v = RST_N & (owner ? REQ1_VALID : REQ0_VALID);
    acc = mem_v & MEM_READY;
    state_d = state_q == IDLE ? ((mem_v & ~MEM_READY) ? (owner ? LOCK1 : LOCK0) : IDLE) :
              (MEM_READY ? IDLE : state_q);
  end
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      last_q    <= PORT_DATA;
      pend_v_q  <= 1'b0;
      pend_id_q <= PORT_IF;
    end else begin
      state_q   <= state_d;
      last_q    <= acc ? owner : last_q;
      pend_v_q  <= acc;
      pend_id_q <= owner;
    end
  end
  mux2 #(.W(32)) u_addr  (.sel_i(owner), .a_i(REQ0_ADDR),  .b_i(REQ1_ADDR),  .y_o(addr_m));
  mux2 #(.W(32)) u_wdata (.sel_i(owner), .a_i(REQ0_WDATA), .b_i(REQ1_WDATA), .y_o(wdata_m));
  mux2 #(.W(1))  u_we    (.sel_i(owner), .a_i(REQ0_WE),    .b_i(REQ1_WE),    .y_o(we_m));
  mux2 #(.W(2))  u_size  (.sel_i(owner), .a_i(REQ0_SIZE),  .b_i(REQ1_SIZE),  .y_o(size_m));
  assign SEL        = ~RST_N | owner;
  assign MEM_VALID  = mem_v;
  assign MEM_ADDR   = RST_N ? addr_m : '0;
  assign MEM_WDATA  = RST_N ? wdata_m : '0;
  assign MEM_WE     = RST_N & we_m;
  assign MEM_SIZE   = RST_N ? size_m : '0;
  assign REQ0_READY = acc & (owner == PORT_IF);
  assign REQ1_READY = acc & (owner == PORT_DATA);
  assign RSP0_VALID = pend_v_q & (pend_id_q == PORT_IF);
  assign RSP1_VALID = pend_v_q & (pend_id_q == PORT_DATA);
  assign RSP0_RDATA = RSP0_VALID ? MEM_RDATA : '0;
  assign RSP1_RDATA = RSP1_VALID ? MEM_RDATA : '0;
endmodule
